rx_seq_logger: RTL and testbench
================================

# rx_seq_logger

- Parametrised successor to the fixed single-purpose receive logger.
- Sits on the GMII receive byte stream in the 125 MHz domain and extracts a big-endian sequence number from each frame at a configurable byte offset.
- Classifies each frame as in-order, gap (lost frames) or stale/duplicate, and accumulates saturating statistics until a configurable frame target is reached.
- Outputs feed the status/LED and readout logic.

## Interface
- `SEQ_OFFSET`, 3: byte index (0 = first byte with `rx_en` high) of the sequence field MSB.
- `SEQ_BYTES`, 3: sequence field length in bytes (1–4); `SW = 8*SEQ_BYTES`.
- `CNT_W`, 32: width of all statistic counters.
- `TARGET`, 80: frames counted before `finished`; 0 = never finish.
- `clk125MHz`  in  1  receive clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rx_en`  in  1  frame-valid; high for the contiguous bytes of one frame.
- `rx_data`  in  8  receive byte, valid when `rx_en`=1.
- `clear`  in  1  synchronous statistics clear; same effect as reset, except that it is synchronous.
- `countp`  out  CNT_W  frames evaluated.
- `okp`  out  CNT_W  in-order frames.
- `lostp`  out  CNT_W  sum of sequence gaps.
- `runtp`  out  CNT_W  frames too short to carry the field.
- `last_seq`  out  SW  sequence number of the last evaluated frame.
- `started`  out  1  sticky; set by the first frame start.
- `finished`  out  1  sticky; `countp` reached `TARGET`.
- `valid`  out  1  one-cycle pulse per evaluated frame.
- `dupp`  out  CNT_W  stale/duplicate frames; present only with the macro (see Configuration).

## Operation
- **Reset values:** every output is 0. FSM is in `IDLE`; `expected` is 0.
- **FSM**
  - `IDLE` → `RUN` on first `rx_en`=1.
  - `RUN` → `DONE` when `countp` becomes `TARGET`.
  - `DONE` ignores all frames until `rst` or `clear`.
- **Byte counter**
  - Cleared while `rx_en`=0; increments per byte with `rx_en`=1.
  - Saturates at `SEQ_OFFSET+SEQ_BYTES`.
  - Bytes at indices `SEQ_OFFSET`..`SEQ_OFFSET+SEQ_BYTES-1` are shifted into `seq_cap` MSB-first.
- **Frame end** (`rx_en` 1→0) while in `RUN`:
  - If fewer than `SEQ_OFFSET+SEQ_BYTES` bytes were received: `runtp`++ only. No `valid`, no `countp` change.
  - Otherwise: `countp`++, `last_seq`=`seq_cap`, and `valid` pulses.
- **First evaluated frame:** `okp`++ and `expected`=`seq_cap`+1.
- **Later frames:** compute `d` = (`seq_cap`−`expected`) mod 2^SW.
  - `d`==0: `okp`++; `expected`++.
  - 0<`d`<2^(SW−1): `lostp` += `d`; `expected`=`seq_cap`+1.
  - `d`≥2^(SW−1): stale/duplicate; `expected` unchanged; `dupp`++ if compiled in.
- **Arithmetic:** all sequence arithmetic is modulo 2^SW, so `2^SW−1` followed by 0 is in-order. All counters saturate at 2^CNT_W−1, including `lostp` on addition.
- **`clear`:** behaves as reset and has priority over a coincident frame end; that frame is discarded.
- **Reset mid-frame:** the partial frame is discarded. After release, the FSM returns to `IDLE` until the next `rx_en` rising edge.

## Timing
- `started` rises the cycle after the first `rx_en`=1 sample.
- `valid` and all counter/`last_seq` updates occur on the same edge: the first edge at which `rx_en` is sampled 0 after a frame, i.e. 1-cycle latency from the last byte.
- `finished` rises on the same edge as the `valid` that makes `countp`==`TARGET`.
- Minimum inter-frame gap is 1 cycle of `rx_en`=0; back-to-back frames are fully evaluated.
- No backpressure; `rx_data` is only sampled when `rx_en`=1.

## Configuration
- `RX_SEQ_LOGGER_DUP_CNT_EN` defined: the `dupp` port and counter exist.
- Undefined: the `dupp` port is absent; stale frames still count in `countp` and all other behaviour is identical.

## Test plan
- **In-order run:** 40 frames of 30 bytes, bytes 3..5 = {0,0,j} for j=0..39, 4-cycle gaps → `countp`=40, `okp`=40, `lostp`=0, `last_seq`=39.
- **Stale repeat:** the above, then 40 frames with seq=30 (`TARGET`=80) → `countp`=80, `okp`=40, `lostp`=0, `dupp`=40, `finished`=1 on the 80th `valid`. An 81st frame is ignored.
- **Gap:** seq 0,1,5,6 → `okp`=3, `lostp`=3, `expected` ends at 7.
- **Wrap:** `SEQ_BYTES`=1, seq 254,255,0,1 → `okp`=4, `lostp`=0. Then seq 200 → `dupp`++.
- **Runt:** 5-byte frame → `runtp`=1, no `valid`, `countp` unchanged.
- **Reset:** `rst` low during byte 4 of frame 2 → all outputs 0 asynchronously. The next full frame seq=7 is treated as first: `okp`=1, `started`=1.

Source files
------------

// File: rtl/rx_seq_logger.sv
`default_nettype none
// ============================================================================
// Module      : rx_seq_logger
// Description : GMII receive-side sequence logger in the 125 MHz domain.
//               Pulls a big-endian sequence number out of each frame at a
//               fixed byte offset. Each frame is classified as in-order,
//               gap (frames lost) or stale/duplicate. Saturating statistics
//               accumulate until TARGET frames have been evaluated.
// Revision    : 1.0 - initial parametrised release
// ----------------------------------------------------------------------------
// Optional feature macro: RX_SEQ_LOGGER_DUP_CNT_EN
//   defined   -> dupp port and stale/duplicate counter exist
//   undefined -> no dupp port; stale frames are still counted in countp
// ----------------------------------------------------------------------------
// Ports:
//   clk125MHz  in   1      receive clock, rising edge
//   rst        in   1      asynchronous active-low reset
//   rx_en      in   1      frame valid (contiguous bytes of one frame)
//   rx_data    in   8      receive byte
//   clear      in   1      synchronous statistics clear (acts as reset)
//   countp     out  CNT_W  frames evaluated
//   okp        out  CNT_W  in-order frames
//   lostp      out  CNT_W  sum of sequence gaps
//   runtp      out  CNT_W  frames too short to carry the field
//   last_seq   out  SW     sequence number of last evaluated frame
//   started    out  1      sticky, first frame start seen
//   finished   out  1      sticky, countp reached TARGET
//   dupp       out  CNT_W  stale/duplicate frames (macro only)
//   valid      out  1      one-cycle pulse per evaluated frame
// ============================================================================
module rx_seq_logger #(
    parameter int SEQ_OFFSET = 3,
    parameter int SEQ_BYTES  = 3,
    parameter int CNT_W      = 32,
    parameter int TARGET     = 80
) (
    input  logic                     clk125MHz,
    input  logic                     rst,
    input  logic                     rx_en,
    input  logic [7:0]               rx_data,
    input  logic                     clear,
    output logic [CNT_W-1:0]         countp,
    output logic [CNT_W-1:0]         okp,
    output logic [CNT_W-1:0]         lostp,
    output logic [CNT_W-1:0]         runtp,
    output logic [8*SEQ_BYTES-1:0]   last_seq,
    output logic                     started,
    output logic                     finished,
`ifdef RX_SEQ_LOGGER_DUP_CNT_EN
    output logic [CNT_W-1:0]         dupp,
`endif
    output logic                     valid
);

    localparam int c_SW   = 8 * SEQ_BYTES;
    localparam int c_NEED = SEQ_OFFSET + SEQ_BYTES;
    localparam int c_BC_W = $clog2(c_NEED + 1);
    localparam int c_AW   = ((CNT_W > c_SW) ? CNT_W : c_SW) + 1;

    localparam logic [c_BC_W-1:0] c_NEED_V   = c_BC_W'(c_NEED);
    localparam logic [c_BC_W-1:0] c_OFF_V    = c_BC_W'(SEQ_OFFSET);
    localparam logic [c_BC_W-1:0] c_BC_ONE   = c_BC_W'(1);
    localparam logic [c_SW-1:0]   c_SEQ_ONE  = c_SW'(1);
    localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  c_TARGET_V = CNT_W'(TARGET);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registered state and next-state values
    // ------------------------------------------------------------------
    state_t              r_state_q,      w_state_d;
    logic [c_BC_W-1:0]   r_bcnt_q,       w_bcnt_d;
    logic [c_SW-1:0]     r_seq_cap_q,    w_seq_cap_d;
    logic [c_SW-1:0]     r_expected_q,   w_expected_d;
    logic                r_have_first_q, w_have_first_d;
    logic                r_rx_en_q,      w_rx_en_d;
    logic [CNT_W-1:0]    r_countp_q,     w_countp_d;
    logic [CNT_W-1:0]    r_okp_q,        w_okp_d;
    logic [CNT_W-1:0]    r_lostp_q,      w_lostp_d;
    logic [CNT_W-1:0]    r_runtp_q,      w_runtp_d;
    logic [c_SW-1:0]     r_last_seq_q,   w_last_seq_d;
    logic                r_started_q,    w_started_d;
    logic                r_finished_q,   w_finished_d;
    logic                r_valid_q,      w_valid_d;
`ifdef RX_SEQ_LOGGER_DUP_CNT_EN
    logic [CNT_W-1:0]    r_dupp_q,       w_dupp_d;
`endif

    logic                w_frame_end;
    logic                w_rise;
    logic [c_SW+7:0]     w_shift;
    logic [c_SW-1:0]     w_diff;

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
        return (v == c_CNT_MAX) ? v : (v + c_CNT_ONE);
    endfunction

    function automatic logic [CNT_W-1:0] f_sat_add(input logic [CNT_W-1:0] a,
                                                   input logic [c_SW-1:0]  b);
        logic [c_AW-1:0] sum;
        sum = c_AW'(a) + c_AW'(b);
        return (sum > c_AW'(c_CNT_MAX)) ? c_CNT_MAX : sum[CNT_W-1:0];
    endfunction

    assign w_frame_end = r_rx_en_q & ~rx_en;
    assign w_rise      = rx_en & ~r_rx_en_q;
    // Shift register input: drop the oldest byte, append the new one.
    assign w_shift     = {r_seq_cap_q, rx_data};
    // Modulo-2^SW distance from the expected sequence number; the MSB
    // separates "ahead of expected" (gap) from "behind" (stale/duplicate).
    assign w_diff      = r_seq_cap_q - r_expected_q;

    always_comb begin
        w_state_d      = r_state_q;
        w_bcnt_d       = r_bcnt_q;
        w_seq_cap_d    = r_seq_cap_q;
        w_expected_d   = r_expected_q;
        w_have_first_d = r_have_first_q;
        w_rx_en_d      = rx_en;
        w_countp_d     = r_countp_q;
        w_okp_d        = r_okp_q;
        w_lostp_d      = r_lostp_q;
        w_runtp_d      = r_runtp_q;
        w_last_seq_d   = r_last_seq_q;
        w_started_d    = r_started_q;
        w_finished_d   = r_finished_q;
        w_valid_d      = 1'b0;
`ifdef RX_SEQ_LOGGER_DUP_CNT_EN
        w_dupp_d       = r_dupp_q;
`endif

        // Byte counter saturates at the field end, so "counter below the
        // saturation value" at frame end identifies a runt.
        if (rx_en) begin
            if (r_bcnt_q != c_NEED_V) begin
                w_bcnt_d = r_bcnt_q + c_BC_ONE;
            end
            if ((r_bcnt_q >= c_OFF_V) && (r_bcnt_q < c_NEED_V)) begin
                w_seq_cap_d = w_shift[c_SW-1:0];
            end
        end else begin
            w_bcnt_d = '0;
        end

        case (r_state_q)
            ST_IDLE: begin
                // Only a true rising edge starts logging, so the tail of a
                // frame interrupted by reset or clear is never evaluated.
                if (w_rise) begin
                    w_state_d   = ST_RUN;
                    w_started_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_frame_end) begin
                    if (r_bcnt_q != c_NEED_V) begin
                        w_runtp_d = f_sat_inc(r_runtp_q);
                    end else begin
                        w_countp_d   = f_sat_inc(r_countp_q);
                        w_last_seq_d = r_seq_cap_q;
                        w_valid_d    = 1'b1;
                        if (!r_have_first_q) begin
                            w_okp_d        = f_sat_inc(r_okp_q);
                            w_expected_d   = r_seq_cap_q + c_SEQ_ONE;
                            w_have_first_d = 1'b1;
                        end else if (w_diff == '0) begin
                            w_okp_d      = f_sat_inc(r_okp_q);
                            w_expected_d = r_expected_q + c_SEQ_ONE;
                        end else if (!w_diff[c_SW-1]) begin
                            w_lostp_d    = f_sat_add(r_lostp_q, w_diff);
                            w_expected_d = r_seq_cap_q + c_SEQ_ONE;
                        end else begin
                            // Stale or duplicate: expected stays put.
`ifdef RX_SEQ_LOGGER_DUP_CNT_EN
                            w_dupp_d = f_sat_inc(r_dupp_q);
`endif
                        end
                        if ((TARGET != 0) && (w_countp_d == c_TARGET_V)) begin
                            w_state_d    = ST_DONE;
                            w_finished_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                // ST_DONE: frames are ignored until reset or clear.
            end
        endcase

        // Clear wins over everything, including a coincident frame end.
        // rx_en history is kept so a frame starting right after clear is
        // still seen as a rising edge.
        if (clear) begin
            w_state_d      = ST_IDLE;
            w_bcnt_d       = '0;
            w_seq_cap_d    = '0;
            w_expected_d   = '0;
            w_have_first_d = 1'b0;
            w_countp_d     = '0;
            w_okp_d        = '0;
            w_lostp_d      = '0;
            w_runtp_d      = '0;
            w_last_seq_d   = '0;
            w_started_d    = 1'b0;
            w_finished_d   = 1'b0;
            w_valid_d      = 1'b0;
`ifdef RX_SEQ_LOGGER_DUP_CNT_EN
            w_dupp_d       = '0;
`endif
        end
    end

    always_ff @(posedge clk125MHz or negedge rst) begin
        if (!rst) begin
            r_state_q      <= ST_IDLE;
            r_bcnt_q       <= '0;
            r_seq_cap_q    <= '0;
            r_expected_q   <= '0;
            r_have_first_q <= 1'b0;
            // Pretend rx_en was high: if reset is released mid-frame the
            // remainder must not look like a new frame start.
            r_rx_en_q      <= 1'b1;
            r_countp_q     <= '0;
            r_okp_q        <= '0;
            r_lostp_q      <= '0;
            r_runtp_q      <= '0;
            r_last_seq_q   <= '0;
            r_started_q    <= 1'b0;
            r_finished_q   <= 1'b0;
            r_valid_q      <= 1'b0;
`ifdef RX_SEQ_LOGGER_DUP_CNT_EN
            r_dupp_q       <= '0;
`endif
        end else begin
            r_state_q      <= w_state_d;
            r_bcnt_q       <= w_bcnt_d;
            r_seq_cap_q    <= w_seq_cap_d;
            r_expected_q   <= w_expected_d;
            r_have_first_q <= w_have_first_d;
            r_rx_en_q      <= w_rx_en_d;
            r_countp_q     <= w_countp_d;
            r_okp_q        <= w_okp_d;
            r_lostp_q      <= w_lostp_d;
            r_runtp_q      <= w_runtp_d;
            r_last_seq_q   <= w_last_seq_d;
            r_started_q    <= w_started_d;
            r_finished_q   <= w_finished_d;
            r_valid_q      <= w_valid_d;
`ifdef RX_SEQ_LOGGER_DUP_CNT_EN
            r_dupp_q       <= w_dupp_d;
`endif
        end
    end

    assign countp   = r_countp_q;
    assign okp      = r_okp_q;
    assign lostp    = r_lostp_q;
    assign runtp    = r_runtp_q;
    assign last_seq = r_last_seq_q;
    assign started  = r_started_q;
    assign finished = r_finished_q;
    assign valid    = r_valid_q;
`ifdef RX_SEQ_LOGGER_DUP_CNT_EN
    assign dupp     = r_dupp_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rx_seq_logger.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_seq_logger
// Description : Scoreboard bench for rx_seq_logger. A frame-level reference
//               model predicts each evaluated frame; a monitor pops the
//               prediction whenever valid pulses and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_seq_logger;

    localparam int     OFF      = 3;
    localparam int     NB       = 3;
    localparam int     NEED     = OFF + NB;
    localparam int     TGT      = 80;
    localparam longint SEQ_MOD  = 64'd1 << (8 * NB);
    localparam longint CNT_MAX  = (64'd1 << 32) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_en;
    logic [7:0]  rx_data;
    logic        clear;
    logic [31:0] countp, okp, lostp, runtp;
    logic [23:0] last_seq;
    logic        started, finished, valid;
`ifdef RX_SEQ_LOGGER_DUP_CNT_EN
    logic [31:0] dupp;
`endif

    rx_seq_logger #(
        .SEQ_OFFSET(OFF),
        .SEQ_BYTES (NB),
        .CNT_W     (32),
        .TARGET    (TGT)
    ) dut (
        .clk125MHz(clk),
        .rst      (rst),
        .rx_en    (rx_en),
        .rx_data  (rx_data),
        .clear    (clear),
        .countp   (countp),
        .okp      (okp),
        .lostp    (lostp),
        .runtp    (runtp),
        .last_seq (last_seq),
        .started  (started),
        .finished (finished),
`ifdef RX_SEQ_LOGGER_DUP_CNT_EN
        .dupp     (dupp),
`endif
        .valid    (valid)
    );

    always #4 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int unsigned cyc;
        logic [63:0] cnt, ok, lost, dup, last;
        logic        fin;
    } rec_t;
    rec_t scb[$];
    rec_t mon_rec;

    // Reference model, kept at frame granularity
    int     m_state;       // 0 idle, 1 logging, 2 target reached
    bit     m_started, m_finished, m_first_seen;
    longint m_expected, m_count, m_ok, m_lost, m_runt, m_dup, m_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint sat(input longint v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic model_reset();
        m_state = 0; m_started = 0; m_finished = 0; m_first_seen = 0;
        m_expected = 0; m_count = 0; m_ok = 0; m_lost = 0; m_runt = 0;
        m_dup = 0; m_last = 0;
    endtask

    task automatic model_start();
        if (m_state == 0) begin
            m_state   = 1;
            m_started = 1;
        end
    endtask

    task automatic model_end(input int len, input longint seq, input int unsigned vcyc);
        longint d;
        rec_t   r;
        if (m_state != 1) return;
        if (len < NEED) begin
            m_runt = sat(m_runt + 1);
            return;
        end
        m_count = sat(m_count + 1);
        m_last  = seq;
        if (!m_first_seen) begin
            m_ok = sat(m_ok + 1);
            m_expected = (seq + 1) % SEQ_MOD;
            m_first_seen = 1;
        end else begin
            d = (seq + SEQ_MOD - m_expected) % SEQ_MOD;
            if (d == 0) begin
                m_ok = sat(m_ok + 1);
                m_expected = (m_expected + 1) % SEQ_MOD;
            end else if (d < SEQ_MOD / 2) begin
                m_lost = sat(m_lost + d);
                m_expected = (seq + 1) % SEQ_MOD;
            end else begin
                m_dup = sat(m_dup + 1);
            end
        end
        if (m_count == TGT) begin
            m_state = 2;
            m_finished = 1;
        end
        r.cyc = vcyc; r.cnt = m_count; r.ok = m_ok; r.lost = m_lost;
        r.dup = m_dup; r.last = m_last; r.fin = m_finished;
        scb.push_back(r);
    endtask

    // Monitor: every valid pulse must match the oldest prediction.
    always @(negedge clk) begin
        if (rst === 1'b1 && valid === 1'b1) begin
            if (scb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                mon_rec = scb.pop_front();
                chk("valid_cycle", 64'(cyc), 64'(mon_rec.cyc));
                chk("v_countp", 64'(countp), mon_rec.cnt);
                chk("v_okp", 64'(okp), mon_rec.ok);
                chk("v_lostp", 64'(lostp), mon_rec.lost);
                chk("v_last_seq", 64'(last_seq), mon_rec.last);
                chk("v_finished", 64'(finished), 64'(mon_rec.fin));
`ifdef RX_SEQ_LOGGER_DUP_CNT_EN
                chk("v_dupp", 64'(dupp), mon_rec.dup);
`endif
            end
        end
    end

    // Full output check at a quiet point (no valid expected now).
    task automatic chk_all(input string tag);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_pending"}, 64'(scb.size()), 64'd0);
        chk({tag, "_countp"}, 64'(countp), 64'(m_count));
        chk({tag, "_okp"}, 64'(okp), 64'(m_ok));
        chk({tag, "_lostp"}, 64'(lostp), 64'(m_lost));
        chk({tag, "_runtp"}, 64'(runtp), 64'(m_runt));
        chk({tag, "_last_seq"}, 64'(last_seq), 64'(m_last));
        chk({tag, "_started"}, 64'(started), 64'(m_started));
        chk({tag, "_finished"}, 64'(finished), 64'(m_finished));
        chk({tag, "_valid"}, 64'(valid), 64'd0);
`ifdef RX_SEQ_LOGGER_DUP_CNT_EN
        chk({tag, "_dupp"}, 64'(dupp), 64'(m_dup));
`endif
    endtask

    function automatic logic [7:0] frame_byte(input int i, input longint seq);
        if (i >= OFF && i < NEED)
            return 8'((seq >> (8 * (NEED - 1 - i))) & 255);
        return 8'($urandom);
    endfunction

    task automatic send_frame(input int len, input longint seq, input int gap, input bit clr_end);
        int unsigned last_cyc;
        model_start();
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            rx_en   = 1'b1;
            rx_data = frame_byte(i, seq);
        end
        last_cyc = cyc;
        @(posedge clk); #1;
        rx_en   = 1'b0;
        rx_data = 8'($urandom);
        if (clr_end) begin
            clear = 1'b1;
            model_reset();
        end else begin
            model_end(len, seq, last_cyc + 2);
        end
        for (int g = 1; g < gap; g++) begin
            @(posedge clk); #1;
            clear   = 1'b0;
            rx_data = 8'($urandom);
        end
        if (clr_end && gap == 1) begin
            @(posedge clk); #1;
            clear = 1'b0;
        end
    endtask

    task automatic clear_pulse();
        @(posedge clk); #1;
        clear = 1'b1;
        model_reset();
        @(posedge clk); #1;
        clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        longint s;
        int     k;
        rst = 1'b0; rx_en = 1'b0; rx_data = 8'h00; clear = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset_held");
        rst = 1'b1;
        chk_all("reset_rel");

        // In-order run
        for (int j = 0; j < 40; j++) send_frame(30, j, $urandom_range(1, 4), 0);
        chk_all("inorder");

        // Stale repeats up to the target, then one ignored frame
        for (int j = 0; j < 40; j++) send_frame(30, 30, $urandom_range(1, 4), 0);
        chk_all("stale");
        send_frame(30, 31, 3, 0);
        chk_all("after_done");

        // Gap
        clear_pulse();
        chk_all("clear");
        send_frame(30, 0, 2, 0); send_frame(30, 1, 1, 0);
        send_frame(30, 5, 3, 0); send_frame(30, 6, 1, 0);
        send_frame(30, 7, 2, 0);
        chk_all("gap");

        // Wrap, then a stale value
        clear_pulse();
        send_frame(20, SEQ_MOD - 2, 1, 0); send_frame(20, SEQ_MOD - 1, 1, 0);
        send_frame(20, 0, 1, 0);           send_frame(20, 1, 2, 0);
        chk_all("wrap");
        send_frame(20, SEQ_MOD - 16, 2, 0);
        chk_all("wrap_stale");

        // Runt and the shortest evaluated length
        send_frame(5, 2, 2, 0);
        chk_all("runt");
        send_frame(NEED, 3, 1, 0);
        chk_all("min_len");

        // Clear coincident with a frame end discards that frame
        send_frame(30, 9, 1, 1);
        chk_all("clear_end");

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 3);
            case (k)
                0: s = m_expected;
                1: s = (m_expected + $urandom_range(1, 5)) % SEQ_MOD;
                2: s = (m_expected + SEQ_MOD - $urandom_range(1, 3)) % SEQ_MOD;
                default: s = longint'($urandom) % SEQ_MOD;
            endcase
            send_frame($urandom_range(1, 20), s, $urandom_range(1, 3), 0);
        end
        chk_all("random");

        // Asynchronous reset during byte 4 of frame 2
        clear_pulse();
        send_frame(30, 3, 2, 0);
        model_start();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            rx_en   = 1'b1;
            rx_data = frame_byte(i, 4);
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("async_countp", 64'(countp), 64'd0);
        chk("async_okp", 64'(okp), 64'd0);
        chk("async_last_seq", 64'(last_seq), 64'd0);
        chk("async_started", 64'(started), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 6; i < 30; i++) begin
            @(posedge clk); #1;
            rx_data = frame_byte(i, 4);
        end
        @(posedge clk); #1;
        rx_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all("rst_partial");
        send_frame(30, 7, 2, 0);
        chk_all("rst_first");

        repeat (4) @(posedge clk);
        #1;
        chk("final_pending", 64'(scb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
